// File: rtl/tlu_trigger_data_fifo_if.sv
// Trigger-data handshake and FWFT read bus between the TLU controller,
// the trigger data FIFO and the readout arbiter.
interface tlu_trigger_data_fifo_if;
   logic [31:0] TLU_DATA;
   logic        TLU_DATA_SAVE_FLAG;
   logic        TLU_DATA_SAVED_FLAG;
   logic        FIFO_READ;
   logic        FIFO_EMPTY;
   logic [31:0] FIFO_DATA;

   modport master (
      output TLU_DATA,
      output TLU_DATA_SAVE_FLAG,
      output FIFO_READ,
      input  TLU_DATA_SAVED_FLAG,
      input  FIFO_EMPTY,
      input  FIFO_DATA
   );

   modport slave (
      input  TLU_DATA,
      input  TLU_DATA_SAVE_FLAG,
      input  FIFO_READ,
      output TLU_DATA_SAVED_FLAG,
      output FIFO_EMPTY,
      output FIFO_DATA
   );
endinterface

// File: rtl/tlu_trigger_data_fifo.sv
// Captures TLU trigger words, acknowledges them and buffers them in a
// first-word-fall-through FIFO with near-full watermark and lost-word counter.
module tlu_trigger_data_fifo #(
   parameter int ADDR_WIDTH       = 4,
   parameter int NEAR_FULL_MARGIN = 4
) (
   input  logic                    BUS_CLK,
   input  logic                    BUS_RST,
   input  logic                    ENABLE,
   tlu_trigger_data_fifo_if.slave  bus,
   output logic                    FIFO_NEAR_FULL,
   output logic [ADDR_WIDTH:0]     FILL_LEVEL,
   output logic [7:0]              LOST_COUNT
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] THRESH_L = (ADDR_WIDTH+1)'(DEPTH - NEAR_FULL_MARGIN);

   logic                  cap_vld_q;
   logic [31:0]           cap_word_q;
   logic [31:0]           mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   fill_q, fill_d;
   logic                  empty_q;
   logic                  near_full_q;
   logic [31:0]           head_q, head_d;
   logic [7:0]            lost_q, lost_d;
   logic                  full;
   logic                  wr_en;
   logic                  drop_full;
   logic                  rd_en;
   logic                  tlu_msb_unused;

   // Bit 31 of the incoming word is replaced by the trigger-word tag.
   assign tlu_msb_unused = bus.TLU_DATA[31];

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         cap_vld_q  <= 1'b0;
         cap_word_q <= '0;
      end else begin
         cap_vld_q  <= bus.TLU_DATA_SAVE_FLAG;
         cap_word_q <= bus.TLU_DATA_SAVE_FLAG ? {1'b1, bus.TLU_DATA[30:0]} : cap_word_q;
      end
   end

   always_comb begin
      full      = (fill_q == DEPTH_L);
      wr_en     = cap_vld_q && ENABLE && !full;
      drop_full = cap_vld_q && ENABLE && full;
      rd_en     = bus.FIFO_READ && !empty_q;
      wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(wr_en);
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(rd_en);

      fill_d = fill_q;
      if (wr_en && !rd_en) begin
         fill_d = fill_q + 1'b1;
      end else if (!wr_en && rd_en) begin
         fill_d = fill_q - 1'b1;
      end

      lost_d = lost_q;
      if (drop_full && (lost_q != 8'hFF)) begin
         lost_d = lost_q + 8'd1;
      end

      // Head bypasses memory when the slot it needs is being written this cycle.
      head_d = head_q;
      if (fill_d != '0) begin
         if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
            head_d = cap_word_q;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= cap_word_q;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         empty_q     <= 1'b1;
         near_full_q <= 1'b0;
         head_q      <= '0;
         lost_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         empty_q     <= (fill_d == '0);
         near_full_q <= (fill_d >= THRESH_L);
         head_q      <= head_d;
         lost_q      <= lost_d;
      end
   end

   assign bus.TLU_DATA_SAVED_FLAG = cap_vld_q;
   assign bus.FIFO_EMPTY          = empty_q;
   assign bus.FIFO_DATA           = head_q;
   assign FIFO_NEAR_FULL          = near_full_q;
   assign FILL_LEVEL              = fill_q;
   assign LOST_COUNT              = lost_q;

endmodule

// File: tb/tb_tlu_trigger_data_fifo.sv
// Self-checking bench for tlu_trigger_data_fifo: vector table for single
// words, scoreboard queue for fill, watermark, overflow, wrap and reset cases.
module tb_tlu_trigger_data_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       near_full;
   logic [4:0] fill;
   logic [7:0] lost;

   tlu_trigger_data_fifo_if bus ();

   tlu_trigger_data_fifo #(.ADDR_WIDTH(4), .NEAR_FULL_MARGIN(4)) dut (
      .BUS_CLK        (clk),
      .BUS_RST        (rst),
      .ENABLE         (enable),
      .bus            (bus),
      .FIFO_NEAR_FULL (near_full),
      .FILL_LEVEL     (fill),
      .LOST_COUNT     (lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic        en;
      logic [31:0] exp_word;
      logic        stored;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] sb [$];
   int          lost_m;
   int          tests = 0;
   int          fails = 0;
   int          saved_cnt = 0;
   int          saved_base;

   always @(negedge clk) begin
      if (bus.TLU_DATA_SAVED_FLAG === 1'b1) saved_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic save(input logic [31:0] d);
      bus.TLU_DATA           = d;
      bus.TLU_DATA_SAVE_FLAG = 1'b1;
      step();
      bus.TLU_DATA_SAVE_FLAG = 1'b0;
      bus.TLU_DATA           = '0;
   endtask

   function automatic void model_write(input logic [31:0] d);
      if (enable) begin
         if (sb.size() < 16) sb.push_back({1'b1, d[30:0]});
         else if (lost_m < 255) lost_m++;
      end
   endfunction

   // Compares the head with the scoreboard and pops it over one cycle.
   task automatic pop_chk(input string name);
      logic [31:0] exp;
      if (sb.size() == 0) begin
         chk({name, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
         exp = sb.pop_front();
         chk({name, "_empty"}, {31'd0, bus.FIFO_EMPTY}, 32'd0);
         chk({name, "_data"}, bus.FIFO_DATA, exp);
      end
      bus.FIFO_READ = 1'b1;
      step();
      bus.FIFO_READ = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      sb.delete();
      lost_m = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;

      vecs[0] = '{32'h0000_1234, 1'b1, 32'h8000_1234, 1'b1};
      vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[2] = '{32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      vecs[3] = '{32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1};
      vecs[4] = '{32'h1234_5678, 1'b1, 32'h9234_5678, 1'b1};
      vecs[5] = '{32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
      vecs[6] = '{32'h8000_0001, 1'b1, 32'h8000_0001, 1'b1};

      rst                    = 1'b1;
      enable                 = 1'b1;
      bus.TLU_DATA           = '0;
      bus.TLU_DATA_SAVE_FLAG = 1'b0;
      bus.FIFO_READ          = 1'b0;
      lost_m                 = 0;
      step();
      step();
      rst = 1'b0;

      chk("rst_saved", {31'd0, bus.TLU_DATA_SAVED_FLAG}, 32'd0);
      chk("rst_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);
      chk("rst_data", bus.FIFO_DATA, 32'd0);
      chk("rst_nf", {31'd0, near_full}, 32'd0);
      chk("rst_fill", {27'd0, fill}, 32'd0);
      chk("rst_lost", {24'd0, lost}, 32'd0);

      // Single-word vectors: ack at N+1, head at N+2, then pop.
      for (int i = 0; i < 7; i++) begin
         enable = vecs[i].en;
         save(vecs[i].din);
         chk($sformatf("v%0d_saved_n1", i), {31'd0, bus.TLU_DATA_SAVED_FLAG}, 32'd1);
         chk($sformatf("v%0d_empty_n1", i), {31'd0, bus.FIFO_EMPTY}, 32'd1);
         step();
         chk($sformatf("v%0d_saved_n2", i), {31'd0, bus.TLU_DATA_SAVED_FLAG}, 32'd0);
         if (vecs[i].stored) begin
            chk($sformatf("v%0d_empty_n2", i), {31'd0, bus.FIFO_EMPTY}, 32'd0);
            chk($sformatf("v%0d_data", i), bus.FIFO_DATA, vecs[i].exp_word);
            chk($sformatf("v%0d_fill", i), {27'd0, fill}, 32'd1);
            bus.FIFO_READ = 1'b1;
            step();
            bus.FIFO_READ = 1'b0;
         end
         chk($sformatf("v%0d_empty_end", i), {31'd0, bus.FIFO_EMPTY}, 32'd1);
         chk($sformatf("v%0d_fill_end", i), {27'd0, fill}, 32'd0);
         chk($sformatf("v%0d_lost", i), {24'd0, lost}, 32'd0);
      end
      enable = 1'b1;

      bus.FIFO_READ = 1'b1;
      step();
      bus.FIFO_READ = 1'b0;
      chk("read_when_empty_fill", {27'd0, fill}, 32'd0);
      chk("read_when_empty_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);

      // Watermark: rises at fill 12, falls on the first pop below it.
      for (int i = 1; i <= 12; i++) begin
         d = 32'h0100_0000 + i;
         model_write(d);
         save(d);
         step();
         chk($sformatf("wm_fill_%0d", i), {27'd0, fill}, i);
         chk($sformatf("wm_nf_%0d", i), {31'd0, near_full}, (i >= 12) ? 32'd1 : 32'd0);
      end
      pop_chk("wm_pop");
      chk("wm_nf_after_pop", {31'd0, near_full}, 32'd0);
      chk("wm_fill_after_pop", {27'd0, fill}, 32'd11);
      while (sb.size() > 0) pop_chk("wm_drain");
      chk("wm_drained_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);

      // Overflow: 20 writes into 16 slots, pointers wrap during the run.
      saved_base = saved_cnt;
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         model_write(d);
         save(d);
         step();
      end
      chk("ovf_fill", {27'd0, fill}, 32'd16);
      chk("ovf_lost", {24'd0, lost}, lost_m);
      chk("ovf_lost_model", lost_m, 32'd4);
      chk("ovf_saved", saved_cnt - saved_base, 32'd20);
      chk("ovf_nf", {31'd0, near_full}, 32'd1);

      // Write into a full FIFO with a same-cycle pop is still dropped.
      d = 32'hCAFE_0001;
      model_write(d);
      save(d);
      pop_chk("full_rw_pop");
      chk("full_rw_fill", {27'd0, fill}, 32'd15);
      chk("full_rw_lost", {24'd0, lost}, lost_m);
      while (sb.size() > 0) pop_chk("ovf_drain");
      chk("ovf_drained_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);
      chk("ovf_drained_fill", {27'd0, fill}, 32'd0);

      do_reset();
      chk("rst2_lost", {24'd0, lost}, 32'd0);

      // Disabled: acknowledged but discarded, not counted as lost.
      enable     = 1'b0;
      saved_base = saved_cnt;
      for (int i = 0; i < 3; i++) begin
         d = 32'h0200_0000 + i;
         model_write(d);
         save(d);
         step();
      end
      chk("dis_saved", saved_cnt - saved_base, 32'd3);
      chk("dis_fill", {27'd0, fill}, 32'd0);
      chk("dis_lost", {24'd0, lost}, 32'd0);
      chk("dis_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);
      enable = 1'b1;

      // One word stored, write and pop together: new word becomes head.
      d = 32'h0300_00AA;
      model_write(d);
      save(d);
      step();
      d = 32'h0300_00BB;
      model_write(d);
      save(d);
      pop_chk("one_rw_pop");
      chk("one_rw_fill", {27'd0, fill}, 32'd1);
      chk("one_rw_head", bus.FIFO_DATA, 32'h8300_00BB);

      // Grow to 5, then write and pop together.
      for (int i = 0; i < 4; i++) begin
         d = 32'h0400_0000 + i;
         model_write(d);
         save(d);
         step();
      end
      chk("five_fill", {27'd0, fill}, 32'd5);
      d = 32'h0400_00FF;
      model_write(d);
      save(d);
      pop_chk("five_rw_pop");
      chk("five_rw_fill", {27'd0, fill}, 32'd5);
      step();
      chk("five_rw_fill_hold", {27'd0, fill}, 32'd5);
      pop_chk("five_next_head");

      // Reset with a capture in flight clears everything.
      save(32'h0500_0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      lost_m = 0;
      chk("mid_rst_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);
      chk("mid_rst_fill", {27'd0, fill}, 32'd0);
      chk("mid_rst_lost", {24'd0, lost}, 32'd0);
      chk("mid_rst_saved", {31'd0, bus.TLU_DATA_SAVED_FLAG}, 32'd0);
      chk("mid_rst_data", bus.FIFO_DATA, 32'd0);
      chk("mid_rst_nf", {31'd0, near_full}, 32'd0);
      step();
      chk("mid_rst_no_write", {27'd0, fill}, 32'd0);
      chk("mid_rst_still_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);

      d = 32'h0600_0042;
      model_write(d);
      save(d);
      step();
      pop_chk("post_rst_pop");
      chk("post_rst_empty", {31'd0, bus.FIFO_EMPTY}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tlu_trigger_data_fifo.md
Name: tlu_trigger_data_fifo

Overview:
- Downstream consumer of the TLU controller's parallel trigger data, in the BUS_CLK domain.
- Captures each 32-bit trigger word on TLU_DATA_SAVE_FLAG and acknowledges it with TLU_DATA_SAVED_FLAG.
- Stores the words in a first-word-fall-through FIFO that is drained by the readout arbiter.
- Drives FIFO_NEAR_FULL back to the TLU controller FSM and counts triggers lost because the FIFO was full.

Parameters:
- ADDR_WIDTH, 4: FIFO depth is 2**ADDR_WIDTH words (default 16).
- NEAR_FULL_MARGIN, 4: FIFO_NEAR_FULL asserts when fill >= 2**ADDR_WIDTH - NEAR_FULL_MARGIN. Legal range is 1..2**ADDR_WIDTH-1.

Ports:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  1 stores trigger words; 0 still acknowledges them but discards them.
- TLU_DATA  in  32  trigger number, valid in the cycle TLU_DATA_SAVE_FLAG is high.
- TLU_DATA_SAVE_FLAG  in  1  one-cycle pulse: trigger data ready.
- TLU_DATA_SAVED_FLAG  out  1  one-cycle acknowledge pulse.
- FIFO_READ  in  1  pop the head word; ignored when FIFO_EMPTY=1.
- FIFO_EMPTY  out  1  FIFO holds no words.
- FIFO_DATA  out  32  head word, valid while FIFO_EMPTY=0.
- FIFO_NEAR_FULL  out  1  fill-level watermark.
- FILL_LEVEL  out  ADDR_WIDTH+1  current number of stored words.
- LOST_COUNT  out  8  saturating count of words dropped because the FIFO was full.

Behaviour:
- Single clock domain; every register is reset synchronously by BUS_RST.
- Reset values:
  - TLU_DATA_SAVED_FLAG=0, FIFO_EMPTY=1, FIFO_DATA=0, FIFO_NEAR_FULL=0, FILL_LEVEL=0, LOST_COUNT=0.
  - Read and write pointers = 0; the capture register is cleared.
- Stored word format is {1'b1, TLU_DATA[30:0]}. Bit 31 tags the word as a trigger word in the readout stream.
- Capture stage:
  - When TLU_DATA_SAVE_FLAG=1 in cycle N, the formatted word is registered together with a valid bit.
  - TLU_DATA_SAVED_FLAG=1 in cycle N+1 for exactly one cycle, regardless of ENABLE or the full state, so the upstream handshake never stalls.
- Write stage, cycle N+1: if valid, ENABLE=1 and FILL_LEVEL < 2**ADDR_WIDTH, the word is written at the write pointer and the write pointer increments (wraps modulo depth).
- Full drop: if valid, ENABLE=1 and the FIFO is full, the word is discarded and LOST_COUNT increments, saturating at 255.
- Disabled drop: if ENABLE=0, the word is discarded and LOST_COUNT is unchanged.
- Full is evaluated on the fill level before any same-cycle read. A write into a full FIFO is dropped even if FIFO_READ pops in the same cycle.
- Read side (first-word fall-through):
  - FIFO_DATA is a register holding mem[read pointer] whenever the FIFO is non-empty.
  - A word written in cycle N+1 into an empty FIFO appears with FIFO_EMPTY=0 in cycle N+2.
  - FIFO_READ=1 with FIFO_EMPTY=0 pops: the read pointer increments (wraps) and the next word, or FIFO_EMPTY=1, is presented the following cycle.
  - FIFO_READ while FIFO_EMPTY=1 has no effect.
- Fill accounting:
  - FILL_LEVEL is registered: +1 on write only, -1 on pop only, unchanged on write and pop together.
  - A simultaneous write and pop is legal whenever the FIFO is neither full nor empty.
  - With one word stored, a simultaneous write and pop holds the new word as head in the next cycle.
- FIFO_NEAR_FULL is registered from the updated FILL_LEVEL, so it asserts in the same cycle FILL_LEVEL reaches threshold and deasserts in the same cycle it drops below.
- TLU_DATA_SAVE_FLAG pulses arrive at least 2 cycles apart; back-to-back pulses are nevertheless accepted one word per cycle.
- Reset in mid-operation: an asserted BUS_RST discards all stored words, any pending capture and any pending SAVED_FLAG in the next cycle.

Test Plan:
- Reset, then SAVE_FLAG with TLU_DATA=0x0000_1234 and ENABLE=1 -> SAVED_FLAG pulse at N+1; FIFO_EMPTY=0 and FIFO_DATA=0x8000_1234 at N+2; FILL_LEVEL=1.
- Write TLU_DATA=0xFFFF_FFFF -> FIFO_DATA=0xFFFF_FFFF (bit 31 forced to 1); one FIFO_READ -> FIFO_EMPTY=1 the next cycle, FILL_LEVEL=0.
- 12 writes with defaults -> FIFO_NEAR_FULL rises exactly when FILL_LEVEL=12; one pop -> FIFO_NEAR_FULL falls.
- 20 writes with no reads -> FILL_LEVEL=16, LOST_COUNT=4, 20 SAVED_FLAG pulses; read-out returns the first 16 words in order across the pointer wrap.
- ENABLE=0 with 3 writes -> 3 SAVED_FLAG pulses, FILL_LEVEL=0, LOST_COUNT=0.
- FIFO holding 5 words, write and FIFO_READ in the same cycle -> FILL_LEVEL stays 5; assert BUS_RST -> FIFO_EMPTY=1, FILL_LEVEL=0, LOST_COUNT=0 the next cycle.
